regfile_ctrl: RTL
=================

# regfile_ctrl

Port controller for the picoMIPS 5 x 8-bit register file. Clears the file after reset, enforces the %0 == 0 rule, and shares the single write port and read port 1 between the core datapath and a debug/loader port. Debug accesses use a req/ack handshake and are starvation-protected by stalling the core. Sits between the core decode/writeback logic and `regs`.

## Interface
- `n`, 8, data width
- `NREGS`, 5, number of implemented registers (addresses 0..NREGS-1)
- `MAXWAIT`, 4, consecutive blocked cycles before the core is stalled for debug
- `clk` input 1 system clock, rising edge
- `reset` input 1 asynchronous, active-high reset
- `core_w` input 1 core writeback request
- `core_waddr` input 5 core destination register
- `core_wdata` input n core writeback data
- `core_raddr1` input 5 core read-port-1 address
- `core_stall` output 1 core must hold its current instruction and write
- `dbg_req` input 1 debug access request, held until ack
- `dbg_we` input 1 1 = write, 0 = read (sampled with req)
- `dbg_addr` input 5 debug register address
- `dbg_wdata` input n debug write data
- `dbg_ack` output 1 one-cycle completion pulse
- `dbg_err` output 1 valid with ack: address out of range
- `dbg_rdata` output n read data, valid with ack, held until next ack
- `rf_w` output 1 to `regs` w
- `rf_waddr` output 5 to `regs` Raddr2 (write address)
- `rf_wdata` output n to `regs` Wdata
- `rf_raddr1` output 5 to `regs` Raddr1
- `rf_rdata1` input n from `regs` Rdata1

## Operation
- States: CLEAR, IDLE, DBG_RD, DBG_DONE.
- CLEAR (entered on reset): counter `clr_idx` 0..NREGS-1; each cycle rf_w=1, rf_waddr=clr_idx, rf_wdata=0; core_stall=1. After idx NREGS-1 -> IDLE. Exactly NREGS write cycles.
- IDLE, no debug: rf_w = core_w && core_waddr!=0 && core_waddr<NREGS; rf_waddr=core_waddr; rf_wdata=core_wdata; rf_raddr1=core_raddr1; core_stall=0.
- Writes to register 0 or out-of-range addresses are always suppressed (rf_w=0). The core path gives no error indication.
- Debug arbitration in IDLE with dbg_req=1:
  - If core_w=0 and core_stall=0, debug is granted this cycle.
  - If core_w=1, the core wins and `wait_cnt` increments.
  - When wait_cnt reaches MAXWAIT, core_stall=1 for the next cycle. The core write is ignored that cycle, debug is granted, and wait_cnt clears.
- Grant, write: rf_w=1 (unless addr 0 or out of range), rf_waddr=dbg_addr, rf_wdata=dbg_wdata. Go to DBG_DONE.
- Grant, read: rf_raddr1=dbg_addr, core_stall=1. Go to DBG_RD. In DBG_RD, capture rf_rdata1 into dbg_rdata (0 if out of range) and go to DBG_DONE.
- DBG_DONE: dbg_ack=1, dbg_err=(dbg_addr>=NREGS). Core path is active as in IDLE. Go to IDLE.
- dbg_req must drop in the cycle after ack. A req still high in IDLE counts as a new request.

## Timing
- Reset values: state=CLEAR, clr_idx=0, wait_cnt=0, dbg_ack=0, dbg_err=0, dbg_rdata=0, core_stall=1, rf_w=1, rf_waddr=0, rf_wdata=0, rf_raddr1=0.
- rf_* outputs are combinational from state and inputs. dbg_ack, dbg_err and dbg_rdata are registered.
- Uncontended debug write: grant cycle T, ack at T+1. Register visible on read port from T+1.
- Uncontended debug read: grant T (stall), capture T+1, ack T+2.
- Worst-case debug latency: MAXWAIT blocked cycles, then 1 stall grant cycle, then ack (+1 for read).
- Reset asserted mid-operation aborts any debug access with no ack and restarts CLEAR. A pending core write in that cycle is lost.
- dbg_req during CLEAR is held off until IDLE. wait_cnt does not count during CLEAR.

## Test plan
- Reset, then release: rf_w=1 with waddr 0,1,2,3,4 and data 0 on 5 consecutive cycles, core_stall=1 throughout, then core_stall=0.
- Core write 0x5A to r3, then core write 0xFF to r0: r3 reads 0x5A; r0 write is suppressed (rf_w=0), r0 reads 0.
- Debug write 0x33 to r2 with core idle: ack one cycle after grant, err=0, r2=0x33. Debug read r2: core_stall for 2 cycles, ack with dbg_rdata=0x33.
- Debug write held against core_w=1 every cycle: exactly 4 blocked cycles, then 1 core_stall cycle with the debug write applied, then ack.
- Debug read of addr 7: ack with err=1, dbg_rdata=0, no rf_w pulse.
- Reset asserted during DBG_RD: no ack, CLEAR sequence restarts, all registers 0 afterwards.

Source files
------------

// File: rtl/regfile_ctrl.sv
// rtl/regfile_ctrl.sv - port controller for the picoMIPS 5 x 8-bit register file
//
// Clears the register file after reset and keeps register 0 at zero. It
// shares the single write port and read port 1 between the core datapath and
// a req/ack debug/loader port. A debug request that is blocked too long by
// core writes stalls the core for one cycle so that the debug access can go in.
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   core_w/waddr/wdata         core writeback request
//   core_raddr1                core read-port-1 address
//   core_stall                 core must hold its current instruction and write
//   dbg_req/we/addr/wdata      debug request, held until dbg_ack
//   dbg_ack/err/rdata          registered completion pulse, range error, read data
//   rf_w/waddr/wdata/raddr1    drive the register file write port and read port 1
//   rf_rdata1                  register file read port 1 data
module regfile_ctrl #(
  parameter int n       = 8,
  parameter int NREGS   = 5,
  parameter int MAXWAIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         core_w,
  input  logic [4:0]   core_waddr,
  input  logic [n-1:0] core_wdata,
  input  logic [4:0]   core_raddr1,
  output logic         core_stall,
  input  logic         dbg_req,
  input  logic         dbg_we,
  input  logic [4:0]   dbg_addr,
  input  logic [n-1:0] dbg_wdata,
  output logic         dbg_ack,
  output logic         dbg_err,
  output logic [n-1:0] dbg_rdata,
  output logic         rf_w,
  output logic [4:0]   rf_waddr,
  output logic [n-1:0] rf_wdata,
  output logic [4:0]   rf_raddr1,
  input  logic [n-1:0] rf_rdata1
);

  localparam int WAIT_W = $clog2(MAXWAIT + 1);

  typedef enum logic [1:0] {CLEAR, IDLE, DBG_RD, DBG_DONE} state_t;

  state_t            state, state_next;
  logic [4:0]        clr_idx;
  logic [WAIT_W-1:0] wait_cnt;

  logic core_ok;
  logic dbg_in_range;
  logic dbg_force;
  logic dbg_grant;
  logic dbg_blocked;

  // A core write needs a nonzero, implemented destination.
  assign core_ok      = core_w && (core_waddr != 5'd0) && (32'(core_waddr) < NREGS);
  assign dbg_in_range = 32'(dbg_addr) < NREGS;

  // After MAXWAIT blocked cycles the debug request wins over the core outright.
  assign dbg_force   = (state == IDLE) && dbg_req && (wait_cnt == WAIT_W'(MAXWAIT));
  assign dbg_grant   = (state == IDLE) && dbg_req && (dbg_force || !core_w);
  assign dbg_blocked = (state == IDLE) && dbg_req && !dbg_grant;

  always_comb begin
    state_next = state;
    core_stall = 1'b0;
    rf_w       = 1'b0;
    rf_waddr   = core_waddr;
    rf_wdata   = core_wdata;
    rf_raddr1  = core_raddr1;
    case (state)
      CLEAR: begin
        rf_w       = 1'b1;
        rf_waddr   = clr_idx;
        rf_wdata   = '0;
        rf_raddr1  = 5'd0;
        core_stall = 1'b1;
        if (clr_idx == 5'(NREGS - 1)) state_next = IDLE;
      end
      IDLE, DBG_DONE: begin
        rf_w = core_ok;
        if (state == DBG_DONE) begin
          state_next = IDLE;
        end else if (dbg_grant) begin
          core_stall = dbg_force;
          if (dbg_we) begin
            rf_w       = (dbg_addr != 5'd0) && dbg_in_range;
            rf_waddr   = dbg_addr;
            rf_wdata   = dbg_wdata;
            state_next = DBG_DONE;
          end else begin
            // The read borrows read port 1, so the core is held off for it.
            rf_w       = 1'b0;
            rf_raddr1  = dbg_addr;
            core_stall = 1'b1;
            state_next = DBG_RD;
          end
        end
      end
      DBG_RD: begin
        core_stall = 1'b1;
        rf_raddr1  = dbg_addr;
        state_next = DBG_DONE;
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= CLEAR;
      clr_idx   <= 5'd0;
      wait_cnt  <= '0;
      dbg_ack   <= 1'b0;
      dbg_err   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      state <= state_next;

      if (state == CLEAR) clr_idx <= clr_idx + 5'd1;
      else                clr_idx <= 5'd0;

      if (dbg_blocked)        wait_cnt <= wait_cnt + WAIT_W'(1);
      else if (state == IDLE) wait_cnt <= '0;

      // Error flag is only meaningful alongside the ack pulse.
      dbg_ack <= (state_next == DBG_DONE);
      dbg_err <= (state_next == DBG_DONE) && !dbg_in_range;

      if (state == DBG_RD) dbg_rdata <= dbg_in_range ? rf_rdata1 : '0;
    end
  end

endmodule
